// File: rtl/qlearn_pkg.sv
// rtl/qlearn_pkg.sv - shared widths, sequencer state type and Q-value saturation
// Contents:
//   STATE_W, ACTION_W, ADDR_WIDTH, DATA_WIDTH  table geometry (64 states x 4 actions, 32-bit Q)
//   CALC_W                                     width of the update arithmetic (3 guard bits)
//   state_t                                    IDLE / RD / CALC / WRITE
//   saturate()                                 clamp a CALC_W value into DATA_WIDTH signed range
package qlearn_pkg;

  localparam int STATE_W    = 6;
  localparam int ACTION_W   = 2;
  localparam int ADDR_WIDTH = STATE_W + ACTION_W;
  localparam int DATA_WIDTH = 32;
  localparam int CALC_W     = DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    CALC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // In range exactly when every bit from the DATA_WIDTH sign bit upward
  // agrees; otherwise the top bit tells which rail to clamp to.
  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [CALC_W-1:0] v);
    logic [CALC_W-DATA_WIDTH:0] upper;
    upper = v[CALC_W-1:DATA_WIDTH-1];
    if (upper == '0 || upper == '1) begin
      return v[DATA_WIDTH-1:0];
    end else if (v[CALC_W-1]) begin
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/qupdate_ctrl_if.sv
// rtl/qupdate_ctrl_if.sv - Q-table BRAM port bundle between the update sequencer and the table
// Signals:
//   o_q_addr_r / o_q_read_en   read address and enable (sequencer -> table)
//   i_q_data                   registered read data, valid one cycle after read enable
//   o_q_addr_w / o_q_write_en  write address and enable (sequencer -> table)
//   o_q_data                   write data (new Q value)
// Modports: master = sequencer side, slave = table side.
interface qupdate_ctrl_if;
  import qlearn_pkg::*;

  logic [ADDR_WIDTH-1:0] o_q_addr_r;
  logic                  o_q_read_en;
  logic [DATA_WIDTH-1:0] i_q_data;
  logic [ADDR_WIDTH-1:0] o_q_addr_w;
  logic                  o_q_write_en;
  logic [DATA_WIDTH-1:0] o_q_data;

  modport master (
    output o_q_addr_r, o_q_read_en, o_q_addr_w, o_q_write_en, o_q_data,
    input  i_q_data
  );

  modport slave (
    input  o_q_addr_r, o_q_read_en, o_q_addr_w, o_q_write_en, o_q_data,
    output i_q_data
  );

endinterface

// File: rtl/qmax4_tracker.sv
// rtl/qmax4_tracker.sv - running signed max/argmax over streamed Q(s',0..3)
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_clear            restart tracking (next valid word becomes the max)
//   i_valid, i_idx     one word per action, presented in ascending action order
//   i_data             signed Q value
//   i_terminal         force max and argmax outputs to zero
//   o_max, o_argmax    current max and its action index
module qmax4_tracker
  import qlearn_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [ACTION_W-1:0]   i_idx,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_terminal,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [ACTION_W-1:0]   o_argmax
);

  logic                         have;
  logic signed [DATA_WIDTH-1:0] max_r;
  logic [ACTION_W-1:0]          arg_r;

  // Strict greater-than: with ascending indices an equal value never
  // displaces the earlier one, so ties resolve to the lowest action.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      have  <= 1'b0;
      max_r <= '0;
      arg_r <= '0;
    end else if (i_clear) begin
      have  <= 1'b0;
      max_r <= '0;
      arg_r <= '0;
    end else if (i_valid && (!have || $signed(i_data) > max_r)) begin
      have  <= 1'b1;
      max_r <= i_data;
      arg_r <= i_idx;
    end
  end

  assign o_max    = i_terminal ? '0 : max_r;
  assign o_argmax = i_terminal ? '0 : arg_r;

endmodule

// File: rtl/qupdate_ctrl.sv
// rtl/qupdate_ctrl.sv - one-shot Q-learning update sequencer over the Q-table BRAM
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_start / o_ready                   request handshake (accepted when both high)
//   i_state, i_action, i_next_state     s, a, s' of the transition
//   i_reward, i_terminal                signed reward, s' terminal flag
//   bus                                 BRAM read/write ports (master side)
//   o_done, o_max_action                write-cycle pulse, greedy action of s'
// Timeline from acceptance (cycle 0): reads in 1-5, data in 2-6, compute in 7,
// write in 8, ready again in 9.
module qupdate_ctrl
  import qlearn_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_ready,
  input  logic [STATE_W-1:0]    i_state,
  input  logic [ACTION_W-1:0]   i_action,
  input  logic [STATE_W-1:0]    i_next_state,
  input  logic [DATA_WIDTH-1:0] i_reward,
  input  logic                  i_terminal,
  qupdate_ctrl_if.master        bus,
  output logic                  o_done,
  output logic [ACTION_W-1:0]   o_max_action
);

  state_t                state;
  logic [2:0]            cnt;
  logic [STATE_W-1:0]    s_r;
  logic [ACTION_W-1:0]   a_r;
  logic [STATE_W-1:0]    ns_r;
  logic [DATA_WIDTH-1:0] r_r;
  logic                  term_r;
  logic [DATA_WIDTH-1:0] q_sa;

  logic                  trk_clear;
  logic                  trk_valid;
  logic [ACTION_W-1:0]   trk_idx;
  logic [DATA_WIDTH-1:0] trk_max;
  logic [ACTION_W-1:0]   trk_arg;

  // cnt tracks the cycle number inside RD (1..6). Words arriving at cnt 3..6
  // belong to actions 0..3 of s'.
  assign trk_clear = (state == IDLE) && i_start;
  assign trk_valid = (state == RD) && (cnt >= 3'd3);
  assign trk_idx   = cnt[1:0] + 2'd1;

  qmax4_tracker u_max (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (trk_clear),
    .i_valid    (trk_valid),
    .i_idx      (trk_idx),
    .i_data     (bus.i_q_data),
    .i_terminal (term_r),
    .o_max      (trk_max),
    .o_argmax   (trk_arg)
  );

  // Update arithmetic with 3 guard bits so no intermediate can wrap.
  logic signed [CALC_W-1:0] r_e, m_e, q_e, target, delta, qn;
  always_comb begin
    r_e    = {{(CALC_W-DATA_WIDTH){r_r[DATA_WIDTH-1]}}, r_r};
    m_e    = {{(CALC_W-DATA_WIDTH){trk_max[DATA_WIDTH-1]}}, trk_max};
    q_e    = {{(CALC_W-DATA_WIDTH){q_sa[DATA_WIDTH-1]}}, q_sa};
    target = r_e + m_e - (m_e >>> GAMMA_SHIFT);
    delta  = target - q_e;
    qn     = q_e + (delta >>> ALPHA_SHIFT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      s_r              <= '0;
      a_r              <= '0;
      ns_r             <= '0;
      r_r              <= '0;
      term_r           <= 1'b0;
      q_sa             <= '0;
      o_ready          <= 1'b1;
      o_done           <= 1'b0;
      o_max_action     <= '0;
      bus.o_q_addr_r   <= '0;
      bus.o_q_read_en  <= 1'b0;
      bus.o_q_addr_w   <= '0;
      bus.o_q_write_en <= 1'b0;
      bus.o_q_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            s_r             <= i_state;
            a_r             <= i_action;
            ns_r            <= i_next_state;
            r_r             <= i_reward;
            term_r          <= i_terminal;
            o_ready         <= 1'b0;
            bus.o_q_read_en <= 1'b1;
            bus.o_q_addr_r  <= {i_state, i_action};
            cnt             <= 3'd1;
            state           <= RD;
          end
        end
        RD: begin
          cnt <= cnt + 3'd1;
          // Address for the following cycle: cnt 1..4 -> {s', 0..3}.
          if (cnt <= 3'd4) begin
            bus.o_q_addr_r <= {ns_r, cnt[1:0] - 2'd1};
          end
          if (cnt == 3'd5) begin
            bus.o_q_read_en <= 1'b0;
          end
          if (cnt == 3'd2) begin
            q_sa <= bus.i_q_data;
          end
          if (cnt == 3'd6) begin
            state <= CALC;
          end
        end
        CALC: begin
          bus.o_q_write_en <= 1'b1;
          bus.o_q_addr_w   <= {s_r, a_r};
          bus.o_q_data     <= saturate(qn);
          o_done           <= 1'b1;
          o_max_action     <= trk_arg;
          state            <= WRITE;
        end
        WRITE: begin
          bus.o_q_write_en <= 1'b0;
          o_done           <= 1'b0;
          o_ready          <= 1'b1;
          cnt              <= '0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qupdate_ctrl.sv
// tb/tb_qupdate_ctrl.sv - directed self-checking bench for qupdate_ctrl with a BRAM model
module tb_qupdate_ctrl;
  import qlearn_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        o_ready;
  logic [5:0]  i_state = '0;
  logic [1:0]  i_action = '0;
  logic [5:0]  i_next_state = '0;
  logic [31:0] i_reward = '0;
  logic        i_terminal = 1'b0;
  logic        o_done;
  logic [1:0]  o_max_action;

  qupdate_ctrl_if bus ();

  qupdate_ctrl #(.ALPHA_SHIFT(2), .GAMMA_SHIFT(3)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .o_ready      (o_ready),
    .i_state      (i_state),
    .i_action     (i_action),
    .i_next_state (i_next_state),
    .i_reward     (i_reward),
    .i_terminal   (i_terminal),
    .bus          (bus),
    .o_done       (o_done),
    .o_max_action (o_max_action)
  );

  always #5 i_clk = ~i_clk;

  // Table model: registered read, bench preload port has priority over DUT write.
  logic [31:0] mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_waddr = '0;
  logic [31:0] tb_wdata = '0;
  int          wr_count = 0;

  always @(posedge i_clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (bus.o_q_write_en) mem[bus.o_q_addr_w] <= bus.o_q_data;
    if (bus.o_q_read_en) bus.i_q_data <= mem[bus.o_q_addr_r];
    if (bus.o_q_write_en) wr_count <= wr_count + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic preload_set(input logic [31:0] qsa, input logic [31:0] q0, input logic [31:0] q1,
                             input logic [31:0] q2, input logic [31:0] q3);
    preload(8'h16, qsa);
    preload(8'h18, q0);
    preload(8'h19, q1);
    preload(8'h1A, q2);
    preload(8'h1B, q3);
  endtask

  // Full cycle-by-cycle check of one update; entered and left at a negedge in IDLE.
  task automatic do_update(input string nm, input logic [5:0] s, input logic [1:0] a,
                           input logic [5:0] ns, input logic [31:0] r, input logic term,
                           input logic [31:0] exp_q, input logic [1:0] exp_act);
    chk({nm, "_ready_c0"}, 32'(o_ready), 32'd1);
    i_state = s; i_action = a; i_next_state = ns; i_reward = r; i_terminal = term;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk({nm, "_rden_c1"}, 32'(bus.o_q_read_en), 32'd1);
    chk({nm, "_addr_c1"}, 32'(bus.o_q_addr_r), 32'({s, a}));
    chk({nm, "_ready_c1"}, 32'(o_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk({nm, "_rden_rd"}, 32'(bus.o_q_read_en), 32'd1);
      chk({nm, "_addr_rd"}, 32'(bus.o_q_addr_r), 32'({ns, k[1:0]}));
    end
    step();
    chk({nm, "_rden_c6"}, 32'(bus.o_q_read_en), 32'd0);
    step();
    chk({nm, "_we_c7"}, 32'(bus.o_q_write_en), 32'd0);
    step();
    chk({nm, "_we_c8"}, 32'(bus.o_q_write_en), 32'd1);
    chk({nm, "_addrw_c8"}, 32'(bus.o_q_addr_w), 32'({s, a}));
    chk({nm, "_data_c8"}, bus.o_q_data, exp_q);
    chk({nm, "_done_c8"}, 32'(o_done), 32'd1);
    chk({nm, "_maxact_c8"}, 32'(o_max_action), 32'(exp_act));
    chk({nm, "_rden_c8"}, 32'(bus.o_q_read_en), 32'd0);
    step();
    chk({nm, "_ready_c9"}, 32'(o_ready), 32'd1);
    chk({nm, "_we_c9"}, 32'(bus.o_q_write_en), 32'd0);
    chk({nm, "_done_c9"}, 32'(o_done), 32'd0);
    chk({nm, "_data_c9"}, bus.o_q_data, exp_q);
  endtask

  int wr_before;

  initial begin
    // Reset values
    repeat (2) @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_rden", 32'(bus.o_q_read_en), 32'd0);
    chk("rst_we", 32'(bus.o_q_write_en), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_data", bus.o_q_data, 32'd0);
    chk("rst_maxact", 32'(o_max_action), 32'd0);
    chk("rst_addr_r", 32'(bus.o_q_addr_r), 32'd0);
    chk("rst_addr_w", 32'(bus.o_q_addr_w), 32'd0);
    i_rst_n = 1'b1;
    step();

    // Zero table, r=0x100 -> 0x40
    preload_set(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    do_update("zero", 6'd5, 2'd2, 6'd6, 32'h100, 1'b0, 32'h40, 2'd0);
    chk("zero_mem", mem[8'h16], 32'h40);

    // Tie between actions 1 and 2 -> action 1; target 0x70 -> 0x1C
    preload_set(32'h0, 32'h10, 32'h80, 32'h80, 32'hFFFF_FFE0);
    do_update("tie", 6'd5, 2'd2, 6'd6, 32'h0, 1'b0, 32'h1C, 2'd1);

    // Terminal: max term 0, r=0x40 -> 0x10, action 0
    preload_set(32'h0, 32'h10, 32'h80, 32'h80, 32'hFFFF_FFE0);
    do_update("term", 6'd5, 2'd2, 6'd6, 32'h40, 1'b1, 32'h10, 2'd0);

    // Positive and negative saturation
    preload_set(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_update("satp", 6'd5, 2'd2, 6'd6, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 2'd0);
    preload_set(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    do_update("satn", 6'd5, 2'd2, 6'd6, 32'h8000_0000, 1'b0, 32'h8000_0000, 2'd0);

    // Reset in cycle 3: no write, table untouched
    preload_set(32'h1234, 32'h0, 32'h0, 32'h0, 32'h0);
    wr_before = wr_count;
    i_state = 6'd5; i_action = 2'd2; i_next_state = 6'd6; i_reward = 32'h100; i_terminal = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    step();
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_rden", 32'(bus.o_q_read_en), 32'd0);
    step();
    step();
    i_rst_n = 1'b1;
    repeat (10) step();
    chk("mid_rst_nowrite", 32'(wr_count), 32'(wr_before));
    chk("mid_rst_ready_after", 32'(o_ready), 32'd1);
    chk("mid_rst_mem", mem[8'h16], 32'h1234);

    // Start held high: first result uses r sampled at acceptance, second
    // accepted in cycle 9 and reads the value written in cycle 8.
    preload_set(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    i_state = 6'd5; i_action = 2'd2; i_next_state = 6'd6; i_reward = 32'h100; i_terminal = 1'b0;
    i_start = 1'b1;
    step();
    chk("b2b_ready_c1", 32'(o_ready), 32'd0);
    i_reward = 32'h200;
    step();
    chk("b2b_ready_c2", 32'(o_ready), 32'd0);
    chk("b2b_addr_c2", 32'(bus.o_q_addr_r), 32'h18);
    repeat (6) step();
    chk("b2b_we_c8", 32'(bus.o_q_write_en), 32'd1);
    chk("b2b_data_c8", bus.o_q_data, 32'h40);
    step();
    chk("b2b_ready_c9", 32'(o_ready), 32'd1);
    step();
    i_start = 1'b0;
    chk("b2b_rden_c10", 32'(bus.o_q_read_en), 32'd1);
    chk("b2b_addr_c10", 32'(bus.o_q_addr_r), 32'h16);
    chk("b2b_ready_c10", 32'(o_ready), 32'd0);
    repeat (7) step();
    chk("b2b_we_c17", 32'(bus.o_q_write_en), 32'd1);
    chk("b2b_data_c17", bus.o_q_data, 32'hB0);
    chk("b2b_done_c17", 32'(o_done), 32'd1);
    step();
    chk("b2b_ready_c18", 32'(o_ready), 32'd1);
    chk("b2b_mem", mem[8'h16], 32'hB0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
